// File: rtl/hier_node_router_pkg.sv
// Shared types and helpers for the hierarchy node router and its merge stage.
package hier_node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int DROP_CNT_W = 8;
    localparam int MAX_CHILD  = 16;

    // One-hot child select; out-of-range selects give an all-zero vector.
    function automatic logic [MAX_CHILD-1:0] onehot_sel(input int unsigned sel);
        onehot_sel = '0;
        if (sel < MAX_CHILD)
            onehot_sel[sel[3:0]] = 1'b1;
    endfunction

endpackage

// File: rtl/hier_node_router_merge.sv
// Combinational response merge: ORs data/err of expected children, flags strays.
module hier_node_merge #(
    parameter int N_CHILD = 5,
    parameter int DATA_W  = 32
) (
    input  logic [N_CHILD-1:0]        rsp_fire_i,
    input  logic [N_CHILD-1:0]        rsp_mask_i,
    input  logic [N_CHILD*DATA_W-1:0] rsp_data_i,
    input  logic [N_CHILD-1:0]        rsp_err_i,
    output logic [N_CHILD-1:0]        hit_o,
    output logic [N_CHILD-1:0]        drop_o,
    output logic [DATA_W-1:0]         hit_data_o,
    output logic                      hit_err_o
);

    assign hit_o  = rsp_fire_i & rsp_mask_i;
    assign drop_o = rsp_fire_i & ~rsp_mask_i;

    always_comb begin
        hit_data_o = '0;
        for (int i = 0; i < N_CHILD; i++) begin
            if (hit_o[i])
                hit_data_o = hit_data_o | rsp_data_i[i*DATA_W +: DATA_W];
        end
        hit_err_o = |(hit_o & rsp_err_i);
    end

endmodule

// File: rtl/hier_node_router.sv
// Hierarchy node: routes one upstream request to a child (or all children),
// merges the child responses and returns a single upstream response.
module hier_node_router
    import hier_node_pkg::*;
#(
    parameter int N_CHILD = 5,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int SEL_LSB = 0,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up_req_valid,
    output logic                      up_req_ready,
    input  logic                      up_req_bcast,
    input  logic [ADDR_W-1:0]         up_req_addr,
    input  logic [DATA_W-1:0]         up_req_data,
    output logic [N_CHILD-1:0]        dn_req_valid,
    input  logic [N_CHILD-1:0]        dn_req_ready,
    output logic [ADDR_W-1:0]         dn_req_addr,
    output logic [DATA_W-1:0]         dn_req_data,
    input  logic [N_CHILD-1:0]        dn_rsp_valid,
    output logic [N_CHILD-1:0]        dn_rsp_ready,
    input  logic [N_CHILD*DATA_W-1:0] dn_rsp_data,
    input  logic [N_CHILD-1:0]        dn_rsp_err,
    output logic                      up_rsp_valid,
    input  logic                      up_rsp_ready,
    output logic [DATA_W-1:0]         up_rsp_data,
    output logic                      up_rsp_err,
    output logic                      busy,
    output logic [DROP_CNT_W-1:0]     drop_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    if (N_CHILD < 1 || N_CHILD > MAX_CHILD || (1 << SEL_W) < N_CHILD ||
        TIMEOUT < 1 || SEL_LSB + SEL_W > ADDR_W) begin : g_param_err
        $error("hier_node_router: illegal parameter combination");
    end

    state_e                  state_q;
    logic [N_CHILD-1:0]      issue_mask_q, issue_mask_d;
    logic [N_CHILD-1:0]      rsp_mask_q, rsp_mask_d;
    logic [TMR_W-1:0]        timer_q;
    logic [DATA_W-1:0]       acc_data_q;
    logic                    acc_err_q;
    logic [ADDR_W-1:0]       req_addr_q;
    logic [DATA_W-1:0]       req_data_q;
    logic [DROP_CNT_W-1:0]   drop_cnt_q;

    logic [SEL_W-1:0]        sel;
    logic                    sel_oob;
    logic                    timer_expired;
    logic [N_CHILD-1:0]      rsp_fire, hit, drop;
    logic [DATA_W-1:0]       hit_data;
    logic                    hit_err;

    assign sel           = up_req_addr[SEL_LSB +: SEL_W];
    assign sel_oob       = 32'(sel) >= 32'(N_CHILD);
    assign timer_expired = (timer_q == TMR_W'(TIMEOUT - 1));

    assign up_req_ready  = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign dn_req_valid  = (state_q == ISSUE) ? issue_mask_q : '0;
    assign dn_req_addr   = req_addr_q;
    assign dn_req_data   = req_data_q;
    // Children may answer in any state but RESP; unexpected answers count as drops.
    assign dn_rsp_ready  = {N_CHILD{state_q != RESP}};
    assign up_rsp_valid  = (state_q == RESP);
    assign up_rsp_data   = acc_data_q;
    assign up_rsp_err    = acc_err_q;
    assign drop_cnt      = drop_cnt_q;

    assign rsp_fire      = dn_rsp_valid & dn_rsp_ready;
    assign issue_mask_d  = issue_mask_q & ~dn_req_ready;
    assign rsp_mask_d    = rsp_mask_q & ~hit;

    hier_node_merge #(
        .N_CHILD (N_CHILD),
        .DATA_W  (DATA_W)
    ) u_merge (
        .rsp_fire_i (rsp_fire),
        .rsp_mask_i (rsp_mask_q),
        .rsp_data_i (dn_rsp_data),
        .rsp_err_i  (dn_rsp_err),
        .hit_o      (hit),
        .drop_o     (drop),
        .hit_data_o (hit_data),
        .hit_err_o  (hit_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_mask_q <= '0;
            rsp_mask_q   <= '0;
            timer_q      <= '0;
            acc_data_q   <= '0;
            acc_err_q    <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (|drop && drop_cnt_q != '1)
                drop_cnt_q <= drop_cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (up_req_valid) begin
                        req_addr_q <= up_req_addr;
                        req_data_q <= up_req_data;
                        if (!up_req_bcast && sel_oob) begin
                            acc_data_q <= '0;
                            acc_err_q  <= 1'b1;
                            state_q    <= RESP;
                        end else begin
                            issue_mask_q <= up_req_bcast ? {N_CHILD{1'b1}}
                                                         : N_CHILD'(onehot_sel(32'(sel)));
                            rsp_mask_q   <= up_req_bcast ? {N_CHILD{1'b1}}
                                                         : N_CHILD'(onehot_sel(32'(sel)));
                            acc_data_q   <= '0;
                            acc_err_q    <= 1'b0;
                            timer_q      <= '0;
                            state_q      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    issue_mask_q <= issue_mask_d;
                    rsp_mask_q   <= rsp_mask_d;
                    acc_data_q   <= acc_data_q | hit_data;
                    acc_err_q    <= acc_err_q | hit_err;
                    if (issue_mask_d == '0)
                        state_q <= WAIT;
                end
                WAIT: begin
                    timer_q    <= timer_q + 1'b1;
                    acc_data_q <= acc_data_q | hit_data;
                    rsp_mask_q <= rsp_mask_d;
                    if (rsp_mask_d == '0) begin
                        acc_err_q <= acc_err_q | hit_err;
                        state_q   <= RESP;
                    end else if (timer_expired) begin
                        // Give up on silent children; their late answers become drops.
                        acc_err_q  <= 1'b1;
                        rsp_mask_q <= '0;
                        state_q    <= RESP;
                    end else begin
                        acc_err_q <= acc_err_q | hit_err;
                    end
                end
                RESP: begin
                    if (up_rsp_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hier_node_router.sv
// Directed bench for hier_node_router (N_CHILD=5, TIMEOUT=10).
module tb_hier_node_router;

    localparam int NC = 5;
    localparam int DW = 32;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            up_req_valid, up_req_ready, up_req_bcast;
    logic [AW-1:0]   up_req_addr;
    logic [DW-1:0]   up_req_data;
    logic [NC-1:0]   dn_req_valid, dn_req_ready;
    logic [AW-1:0]   dn_req_addr;
    logic [DW-1:0]   dn_req_data;
    logic [NC-1:0]   dn_rsp_valid, dn_rsp_ready, dn_rsp_err;
    logic [NC*DW-1:0] dn_rsp_data;
    logic            up_rsp_valid, up_rsp_ready, up_rsp_err;
    logic [DW-1:0]   up_rsp_data;
    logic            busy;
    logic [7:0]      drop_cnt;

    int total = 0;
    int bad   = 0;

    int          acc_cyc [NC] = '{1, 1, 3, 2, 5};
    logic [NC-1:0] exp_vld [6] = '{5'b11111, 5'b11100, 5'b10100, 5'b10000, 5'b10000, 5'b00000};

    always #5 clk = ~clk;

    hier_node_router #(
        .N_CHILD (NC), .DATA_W (DW), .ADDR_W (AW),
        .SEL_LSB (0), .SEL_W (3), .TIMEOUT (10)
    ) dut (
        .clk (clk), .rst (rst),
        .up_req_valid (up_req_valid), .up_req_ready (up_req_ready),
        .up_req_bcast (up_req_bcast), .up_req_addr (up_req_addr),
        .up_req_data (up_req_data),
        .dn_req_valid (dn_req_valid), .dn_req_ready (dn_req_ready),
        .dn_req_addr (dn_req_addr), .dn_req_data (dn_req_data),
        .dn_rsp_valid (dn_rsp_valid), .dn_rsp_ready (dn_rsp_ready),
        .dn_rsp_data (dn_rsp_data), .dn_rsp_err (dn_rsp_err),
        .up_rsp_valid (up_rsp_valid), .up_rsp_ready (up_rsp_ready),
        .up_rsp_data (up_rsp_data), .up_rsp_err (up_rsp_err),
        .busy (busy), .drop_cnt (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        up_req_valid = 0; up_req_bcast = 0; up_req_addr = '0; up_req_data = '0;
        dn_req_ready = '0; dn_rsp_valid = '0; dn_rsp_err = '0; dn_rsp_data = '0;
        up_rsp_ready = 0;
        step(); step();

        // reset state
        chk("rst_req_ready", up_req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dn_req_valid", dn_req_valid, 0);
        chk("rst_up_rsp_valid", up_rsp_valid, 0);
        chk("rst_up_rsp_data", up_rsp_data, 0);
        chk("rst_up_rsp_err", up_rsp_err, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        step();
        chk("idle_rsp_ready", dn_rsp_ready, 5'b11111);

        // unicast to child 2, minimum latency
        up_req_valid = 1; up_req_addr = 8'h02; up_req_data = 32'hA5;
        dn_req_ready = '1;
        dn_rsp_data[2*DW +: DW] = 32'h1234;
        chk("uc_req_ready", up_req_ready, 1);
        step();                                   // cycle 1
        up_req_valid = 0;
        chk("uc_dn_req_valid", dn_req_valid, 5'b00100);
        chk("uc_dn_req_addr", dn_req_addr, 8'h02);
        chk("uc_dn_req_data", dn_req_data, 32'hA5);
        chk("uc_busy", busy, 1);
        step();                                   // cycle 2
        chk("uc_wait_valid", dn_req_valid, 0);
        chk("uc_wait_rsp_valid", up_rsp_valid, 0);
        dn_rsp_valid[2] = 1;
        step();                                   // cycle 3
        dn_rsp_valid = '0;
        chk("uc_rsp_valid", up_rsp_valid, 1);
        chk("uc_rsp_data", up_rsp_data, 32'h1234);
        chk("uc_rsp_err", up_rsp_err, 0);
        chk("uc_resp_rsp_ready", dn_rsp_ready, 0);
        up_rsp_ready = 1;
        step();
        up_rsp_ready = 0;
        chk("uc_done_valid", up_rsp_valid, 0);
        chk("uc_done_busy", busy, 0);
        chk("uc_drop", drop_cnt, 0);

        // broadcast with staggered accepts; addr sel=7 is ignored for broadcast
        dn_req_ready = '0;
        for (int i = 0; i < NC; i++) dn_rsp_data[i*DW +: DW] = 32'(1) << i;
        dn_rsp_err = 5'b01000;
        up_req_valid = 1; up_req_bcast = 1; up_req_addr = 8'h07; up_req_data = 32'h55;
        step();                                   // cycle 1
        up_req_valid = 0; up_req_bcast = 0;
        for (int c = 1; c <= 6; c++) begin
            for (int i = 0; i < NC; i++) begin
                dn_req_ready[i] = (c == acc_cyc[i]);
                dn_rsp_valid[i] = (c == acc_cyc[i] + 1);
            end
            chk($sformatf("bc_dn_req_valid_c%0d", c), dn_req_valid, exp_vld[c-1]);
            chk($sformatf("bc_no_rsp_c%0d", c), up_rsp_valid, 0);
            step();
        end                                       // cycle 7
        dn_req_ready = '0; dn_rsp_valid = '0; dn_rsp_err = '0;
        chk("bc_rsp_valid", up_rsp_valid, 1);
        chk("bc_rsp_data", up_rsp_data, 32'h1F);
        chk("bc_rsp_err", up_rsp_err, 1);
        step();
        chk("bc_rsp_hold_valid", up_rsp_valid, 1);
        chk("bc_rsp_hold_data", up_rsp_data, 32'h1F);
        up_rsp_ready = 1;
        step();
        up_rsp_ready = 0;
        chk("bc_done_busy", busy, 0);
        chk("bc_drop", drop_cnt, 0);

        // unicast to nonexistent child 6
        dn_req_ready = '1;
        up_req_valid = 1; up_req_addr = 8'h06; up_req_data = 32'h99;
        step();
        up_req_valid = 0;
        chk("oob_dn_req_valid", dn_req_valid, 0);
        chk("oob_rsp_valid", up_rsp_valid, 1);
        chk("oob_rsp_data", up_rsp_data, 0);
        chk("oob_rsp_err", up_rsp_err, 1);
        up_rsp_ready = 1;
        step();
        up_rsp_ready = 0;
        chk("oob_done_busy", busy, 0);

        // child 1 never answers: timeout after 10 WAIT cycles
        up_req_valid = 1; up_req_addr = 8'h01; up_req_data = 32'h11;
        step();                                   // cycle 1
        up_req_valid = 0;
        chk("to_dn_req_valid", dn_req_valid, 5'b00010);
        for (int c = 2; c <= 11; c++) step();    // cycles 2..11 in WAIT
        chk("to_still_waiting", up_rsp_valid, 0);
        step();                                   // cycle 12
        chk("to_rsp_valid", up_rsp_valid, 1);
        chk("to_rsp_err", up_rsp_err, 1);
        chk("to_rsp_data", up_rsp_data, 0);
        up_rsp_ready = 1;
        step();
        up_rsp_ready = 0;
        dn_rsp_valid[1] = 1;                      // late answer
        step();
        dn_rsp_valid = '0;
        chk("to_late_drop", drop_cnt, 1);
        chk("to_late_no_rsp", up_rsp_valid, 0);

        // stray responses from child 4 while idle: saturate at 255
        dn_rsp_valid[4] = 1;
        for (int k = 0; k < 254; k++) step();
        chk("sat_reach", drop_cnt, 255);
        for (int k = 0; k < 46; k++) step();
        dn_rsp_valid = '0;
        chk("sat_hold", drop_cnt, 255);

        // reset during WAIT of a broadcast
        up_req_valid = 1; up_req_bcast = 1; up_req_addr = 8'h00;
        step();                                   // cycle 1
        up_req_valid = 0; up_req_bcast = 0;
        step();                                   // cycle 2 (WAIT)
        chk("rw_busy_before", busy, 1);
        rst = 1;
        step();
        rst = 0;
        chk("rw_busy", busy, 0);
        chk("rw_dn_req_valid", dn_req_valid, 0);
        chk("rw_up_rsp_valid", up_rsp_valid, 0);
        chk("rw_drop", drop_cnt, 0);
        chk("rw_req_ready", up_req_ready, 1);
        step();

        // unicast to child 4 (addr 0x0C, upper bits ignored) after reset
        dn_rsp_data[4*DW +: DW] = 32'hCAFE;
        up_req_valid = 1; up_req_addr = 8'h0C; up_req_data = 32'h77;
        step();
        up_req_valid = 0;
        chk("pr_dn_req_valid", dn_req_valid, 5'b10000);
        step();
        dn_rsp_valid[4] = 1;
        step();
        dn_rsp_valid = '0;
        chk("pr_rsp_valid", up_rsp_valid, 1);
        chk("pr_rsp_data", up_rsp_data, 32'hCAFE);
        chk("pr_rsp_err", up_rsp_err, 0);
        up_rsp_ready = 1;
        step();
        up_rsp_ready = 0;
        chk("pr_done_busy", busy, 0);
        chk("pr_drop", drop_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
